// File: rtl/d1_reader_pkg.sv
// rtl/d1_reader_pkg.sv - shared state encoding and sizing for the D1 FIFO reader
package d1_reader_pkg;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   localparam int SKID_DEPTH = 2;
   localparam int CNT_W      = 16;

endpackage

// File: rtl/d1_skid_buffer.sv
// rtl/d1_skid_buffer.sv - 2-entry skid buffer absorbing the FIFO read latency
import d1_reader_pkg::*;

module d1_skid_buffer #(
   parameter int DW = 6
) (
   input  logic          clk,
   input  logic          reset_L,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_flush,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   output logic [DW-1:0] o_data,
   output logic [1:0]    o_occ
);

   logic [DW-1:0] r_mem [SKID_DEPTH];
   logic          r_head;
   logic [1:0]    r_occ;
   logic          w_tail;
   logic          w_pop;

   // With occ=2 the tail wraps onto the head slot, which is only legal alongside a pop.
   assign w_tail  = r_head ^ r_occ[0];
   assign w_pop   = i_pop & (r_occ != 2'd0);
   assign o_valid = (r_occ != 2'd0);
   assign o_data  = o_valid ? r_mem[r_head] : '0;
   assign o_occ   = r_occ;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_head   <= 1'b0;
         r_occ    <= 2'd0;
         r_mem[0] <= '0;
         r_mem[1] <= '0;
      end else if (i_flush) begin
         r_head <= 1'b0;
         r_occ  <= 2'd0;
      end else begin
         if (i_push) r_mem[w_tail] <= i_data;
         if (w_pop) r_head <= ~r_head;
         r_occ <= r_occ + {1'b0, i_push} - {1'b0, w_pop};
      end
   end

endmodule

// File: rtl/d1_fifo_reader.sv
// rtl/d1_fifo_reader.sv - D1 FIFO read controller with skid-buffered output stream
// Optional D1_READER_CNT_EN adds the word_count pop counter output.
import d1_reader_pkg::*;

module d1_fifo_reader #(
   parameter int data_width = 6
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  init,
   input  logic [3:0]            umbral_in,
   output logic [3:0]            Umbral_D1,
   input  logic                  empty_fifo_D1,
   input  logic                  error_D1,
   input  logic [data_width-1:0] data_out_D1,
   output logic                  rd_enable_D1,
   output logic                  valid_out,
   output logic [data_width-1:0] data_out,
   input  logic                  ready_in,
   output logic                  error_out,
   output logic [1:0]            state
`ifdef D1_READER_CNT_EN
  ,output logic [CNT_W-1:0]      word_count
`endif
);

   state_t     r_state;
   logic       r_inflight;
   logic       r_error;
   logic [3:0] r_umbral;
   logic       w_flush;
   logic       w_pop;
   logic       w_rd;
   logic       w_credit;
   logic       w_valid;
   logic [1:0] w_occ;

   assign w_flush = !init || (r_state == ST_INIT);
   assign w_pop   = w_valid & ready_in;
   // Words already held or on their way must leave room for the one we are about to request.
   assign w_credit = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'(SKID_DEPTH) + {2'b00, w_pop});
   assign w_rd     = (r_state == ST_ACTIVE) & init & !empty_fifo_D1 & w_credit;

   d1_skid_buffer #(.DW(data_width)) u_skid (
      .clk     (clk),
      .reset_L (reset_L),
      .i_push  (r_inflight),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (data_out_D1),
      .o_valid (w_valid),
      .o_data  (data_out),
      .o_occ   (w_occ)
   );

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_state    <= ST_INIT;
         r_inflight <= 1'b0;
         r_error    <= 1'b0;
         r_umbral   <= 4'd0;
      end else begin
         r_inflight <= w_rd;
         if (r_state == ST_INIT) r_umbral <= umbral_in;
         if (!init) begin
            r_state <= ST_INIT;
            r_error <= 1'b0;
         end else begin
            case (r_state)
               ST_INIT: r_state <= ST_IDLE;
               ST_IDLE: begin
                  if (error_D1) begin
                     r_state <= ST_ERROR;
                     r_error <= 1'b1;
                  end else if (!empty_fifo_D1) begin
                     r_state <= ST_ACTIVE;
                  end
               end
               ST_ACTIVE: begin
                  if (error_D1) begin
                     r_state <= ST_ERROR;
                     r_error <= 1'b1;
                  end else if (empty_fifo_D1 && (w_occ == 2'd0) && !r_inflight) begin
                     r_state <= ST_IDLE;
                  end
               end
               ST_ERROR: r_state <= ST_ERROR;
            endcase
         end
      end
   end

`ifdef D1_READER_CNT_EN
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)     r_count <= '0;
      else if (w_flush) r_count <= '0;
      else if (w_pop)   r_count <= r_count + 1'b1;
   end

   assign word_count = r_count;
`endif

   assign rd_enable_D1 = w_rd;
   assign valid_out    = w_valid;
   assign error_out    = r_error;
   assign state        = r_state;
   assign Umbral_D1    = r_umbral;

endmodule
